// File: rtl/bus_change_logger.sv
// Change logger for a monitored bus: timestamps every value change and queues
// {ts, value, drop} records in a first-word-fall-through FIFO drained over valid/ready.
module bus_change_logger #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W-1:0]            out_ts,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_drop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state_r;
    logic [TS_W-1:0]     ts_r;
    logic [DATA_W-1:0]   prev_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                overflow_r;
    logic                drop_pend_r;

    logic [TS_W-1:0]     ts_mem_r   [DEPTH];
    logic [DATA_W-1:0]   data_mem_r [DEPTH];
    logic                drop_mem_r [DEPTH];

    logic                capture_s;
    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;

    // Capture decision: ARM always records the starting value, RUN only on change.
    always_comb begin
        capture_s = 1'b0;
        case (state_r)
            ARM:     capture_s = 1'b1;
            RUN:     capture_s = en && (sample_in != prev_r);
            default: capture_s = 1'b0;
        endcase
    end

    assign empty_s = (count_r == CW'(0));
    assign full_s  = (count_r == CW'(DEPTH));
    assign pop_s   = !empty_s && out_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push_s  = capture_s && (!full_s || pop_s);
    assign drop_s  = capture_s && full_s && !pop_s;

    // Free-running timestamp and capture FSM with the previous-value register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_r    <= {TS_W{1'b0}};
            prev_r  <= {DATA_W{1'b0}};
            state_r <= IDLE;
        end else begin
            ts_r <= ts_r + TS_W'(1);
            case (state_r)
                IDLE: begin
                    state_r <= en ? ARM : IDLE;
                end
                ARM: begin
                    prev_r  <= sample_in;
                    state_r <= en ? RUN : IDLE;
                end
                RUN: begin
                    prev_r  <= sample_in;
                    state_r <= en ? RUN : IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy, sticky overflow and pending-drop marker.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            drop_pend_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
            if (drop_s) begin
                drop_pend_r <= 1'b1;
            end else if (push_s) begin
                drop_pend_r <= 1'b0;
            end
        end
    end

    // Record storage; contents are don't-care until the pointers make them live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ts_mem_r[wr_ptr_r]   <= ts_r;
            data_mem_r[wr_ptr_r] <= sample_in;
            drop_mem_r[wr_ptr_r] <= drop_pend_r;
        end
    end

    // Head entry presented directly from storage, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            out_ts   = {TS_W{1'b0}};
            out_data = {DATA_W{1'b0}};
            out_drop = 1'b0;
        end else begin
            out_ts   = ts_mem_r[rd_ptr_r];
            out_data = data_mem_r[rd_ptr_r];
            out_drop = drop_mem_r[rd_ptr_r];
        end
    end

    assign out_valid = !empty_s;
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_bus_change_logger.sv
// Scoreboard bench for bus_change_logger: directed stimulus pushes hand-derived
// records, a monitor pops and compares on every accepted head record.
module tb_bus_change_logger;

    localparam int DATA_W = 8;
    localparam int TS_W   = 16;
    localparam int DEPTH  = 8;
    localparam int CW     = 4;
    localparam int RW     = TS_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic [DATA_W-1:0] sample_in = 8'h00;
    logic              clr_ovf = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TS_W-1:0]   out_ts;
    logic [DATA_W-1:0] out_data;
    logic              out_drop;
    logic [CW-1:0]     count;
    logic              overflow;

    logic [TS_W-1:0]   tb_ts;
    logic [RW-1:0]     exp_q[$];
    int                errors = 0;
    int                checks = 0;

    bus_change_logger #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .en(en), .sample_in(sample_in), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_data(out_data), .out_drop(out_drop), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Cycle counter: value just before each posedge is the ts a capture on that edge carries.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_ts <= 16'h0000;
        else       tb_ts <= tb_ts + 16'h0001;
    end

    // Monitor: every head record accepted on the coming edge is compared with the queue.
    always @(negedge clk) begin
        logic [RW-1:0] e;
        #1;
        if (rstn && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL record_unexpected: got ts=%h data=%h drop=%b, queue empty",
                         out_ts, out_data, out_drop);
            end else begin
                e = exp_q.pop_front();
                if ({out_ts, out_data, out_drop} !== e) begin
                    errors++;
                    $display("FAIL record: got ts=%h data=%h drop=%b, want ts=%h data=%h drop=%b",
                             out_ts, out_data, out_drop, e[RW-1 -: TS_W], e[DATA_W:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; optionally expects a record stamped with this edge's ts.
    task automatic drive(input logic e, input logic [7:0] d, input logic rdy,
                         input logic clr, input logic rec, input logic dr);
        @(negedge clk);
        en = e; sample_in = d; out_ready = rdy; clr_ovf = clr;
        if (rec) exp_q.push_back({tb_ts, d, dr});
    endtask

    task automatic push_exp(input logic [15:0] ts, input logic [7:0] d, input logic dr);
        exp_q.push_back({ts, d, dr});
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_count", {28'd0, count}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_head", {7'd0, out_ts, out_data, out_drop}, 32'd0);
        @(negedge clk);
        rstn = 1'b1; out_ready = 1'b1;

        // Arm at ts=2, initial record captured at ts=3; then changes at 10 and 12.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(16'd3, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(16'd10, 8'h0F, 1'b0);
        drive(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(16'd12, 8'h0A, 1'b0);
        drive(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check("stable_count", {28'd0, count}, 32'd0);

        // Nine changes with consumer stalled: eight queued, ninth dropped.
        for (int i = 1; i <= 9; i++)
            drive(1'b1, 8'(i), 1'b0, 1'b0, (i <= 8), 1'b0);
        drive(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 check("full_count", {28'd0, count}, 32'd8);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        repeat (8) drive(1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check("drained_count", {28'd0, count}, 32'd0);
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous pop and push: accepted, count stays 8.
        for (int i = 0; i < 8; i++)
            drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h17, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 check("fill_count", {28'd0, count}, 32'd8);
        drive(1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 check("pushpop_count", {28'd0, count}, 32'd8);
        check("pushpop_ovf", {31'd0, overflow}, 32'd0);
        repeat (9) drive(1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);

        // Drop coinciding with clr_ovf keeps overflow; clr_ovf alone clears it.
        for (int i = 0; i < 8; i++)
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        drive(1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 check("ovf_clr_alone", {31'd0, overflow}, 32'd0);
        repeat (8) drive(1'b1, 8'h38, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) drive(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-run with five records queued, then re-arm with en held high.
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 check("pre_reset_count", {28'd0, count}, 32'd5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_count", {28'd0, count}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1; out_ready = 1'b1;
        push_exp(16'd1, 8'h54, 1'b0);
        drive(1'b1, 8'h54, 1'b1, 1'b0, 1'b0, 1'b0);

        // Timestamp wrap: changes captured at ts=FFFF and at ts=0000.
        guard = 0;
        while (tb_ts != 16'hFFFE && guard < 70000) begin
            drive(1'b1, 8'h54, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 70000) begin
            errors++;
            $display("FAIL wrap_guard: got %0d cycles, want fewer than 70000", guard);
        end
        push_exp(16'hFFFF, 8'h77, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(16'h0000, 8'h88, 1'b0);
        drive(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
